// File: rtl/stg_ma_pkg.sv
// Shared widths and state encoding for the stg_ma memory-access stage.
package stg_ma_pkg;

    localparam int SIZE_ADDR   = 16;
    localparam int SIZE_DATA   = 32;
    localparam int SIZE_OPC    = 6;
    localparam int SIZE_TGT_GP = 5;
    localparam int SIZE_TGT_SR = 3;

    localparam int HBIT_ADDR   = SIZE_ADDR - 1;
    localparam int HBIT_DATA   = SIZE_DATA - 1;
    localparam int HBIT_OPC    = SIZE_OPC - 1;
    localparam int HBIT_TGT_GP = SIZE_TGT_GP - 1;
    localparam int HBIT_TGT_SR = SIZE_TGT_SR - 1;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/stg_ma_timer.sv
// Counts consecutive memory-wait cycles; flags expiry on the TIMEOUT_CYCLES-th cycle.
module stg_ma_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic iw_clk,
    input  logic iw_rst,
    input  logic iw_run,
    output logic ow_expired
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q;

    assign ow_expired = iw_run && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            cnt_q <= '0;
        end else if (!iw_run) begin
            cnt_q <= '0;
        end else if (!ow_expired) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/stg_ma.sv
// Memory-access pipeline stage: passes ALU ops through, runs load/store handshakes.
// Optional wait timeout with sticky error enabled by defining STG_MA_TIMEOUT_EN.
module stg_ma
    import stg_ma_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                   iw_clk,
    input  logic                   iw_rst,
    input  logic [HBIT_ADDR:0]     iw_pc,
    input  logic [HBIT_DATA:0]     iw_instr,
    input  logic [HBIT_OPC:0]      iw_opc,
    input  logic [HBIT_TGT_GP:0]   iw_tgt_gp,
    input  logic                   iw_tgt_gp_we,
    input  logic [HBIT_TGT_SR:0]   iw_tgt_sr,
    input  logic                   iw_tgt_sr_we,
    input  logic [HBIT_DATA:0]     iw_result,
    input  logic [HBIT_DATA:0]     iw_store_data,
    input  logic                   iw_is_load,
    input  logic                   iw_is_store,
    output logic [HBIT_ADDR:0]     ow_pc,
    output logic [HBIT_DATA:0]     ow_instr,
    output logic [HBIT_OPC:0]      ow_opc,
    output logic [HBIT_TGT_GP:0]   ow_tgt_gp,
    output logic                   ow_tgt_gp_we,
    output logic [HBIT_TGT_SR:0]   ow_tgt_sr,
    output logic                   ow_tgt_sr_we,
    output logic [HBIT_DATA:0]     ow_result,
    output logic                   ow_mem_req,
    output logic                   ow_mem_we,
    output logic [HBIT_ADDR:0]     ow_mem_addr,
    output logic [HBIT_DATA:0]     ow_mem_wdata,
    input  logic                   iw_mem_ack,
    input  logic [HBIT_DATA:0]     iw_mem_rdata,
    output logic                   ow_stall,
    output logic                   ow_mem_err
);

    state_t                 state;
    logic                   mem_op;
    logic                   timeout;
    logic [HBIT_ADDR:0]     hold_pc;
    logic [HBIT_DATA:0]     hold_instr;
    logic [HBIT_OPC:0]      hold_opc;
    logic [HBIT_TGT_GP:0]   hold_tgt_gp;
    logic                   hold_tgt_gp_we;
    logic [HBIT_TGT_SR:0]   hold_tgt_sr;
    logic                   hold_tgt_sr_we;
    logic [HBIT_DATA:0]     hold_result;
    logic                   hold_store;

    assign mem_op   = iw_is_load | iw_is_store;
    assign ow_stall = !iw_rst && ((state == S_IDLE && mem_op) ||
                                  (state == S_WAIT && !iw_mem_ack));

`ifdef STG_MA_TIMEOUT_EN
    logic mem_err_q;

    stg_ma_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .iw_clk     (iw_clk),
        .iw_rst     (iw_rst),
        .iw_run     (state == S_WAIT),
        .ow_expired (timeout)
    );

    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            mem_err_q <= 1'b0;
        end else if (timeout && !iw_mem_ack) begin
            mem_err_q <= 1'b1;
        end
    end

    assign ow_mem_err = mem_err_q;
`else
    assign timeout    = 1'b0;
    assign ow_mem_err = 1'b0;
`endif

    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            state          <= S_IDLE;
            ow_pc          <= '0;
            ow_instr       <= '0;
            ow_opc         <= '0;
            ow_tgt_gp      <= '0;
            ow_tgt_gp_we   <= 1'b0;
            ow_tgt_sr      <= '0;
            ow_tgt_sr_we   <= 1'b0;
            ow_result      <= '0;
            ow_mem_req     <= 1'b0;
            ow_mem_we      <= 1'b0;
            ow_mem_addr    <= '0;
            ow_mem_wdata   <= '0;
            hold_pc        <= '0;
            hold_instr     <= '0;
            hold_opc       <= '0;
            hold_tgt_gp    <= '0;
            hold_tgt_gp_we <= 1'b0;
            hold_tgt_sr    <= '0;
            hold_tgt_sr_we <= 1'b0;
            hold_result    <= '0;
            hold_store     <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    ow_pc     <= iw_pc;
                    ow_instr  <= iw_instr;
                    ow_opc    <= iw_opc;
                    ow_tgt_gp <= iw_tgt_gp;
                    ow_tgt_sr <= iw_tgt_sr;
                    ow_result <= iw_result;
                    if (mem_op) begin
                        // Bubble toward writeback until the access completes.
                        ow_tgt_gp_we   <= 1'b0;
                        ow_tgt_sr_we   <= 1'b0;
                        ow_mem_req     <= 1'b1;
                        ow_mem_we      <= iw_is_store;
                        ow_mem_addr    <= iw_result[HBIT_ADDR:0];
                        ow_mem_wdata   <= iw_store_data;
                        hold_pc        <= iw_pc;
                        hold_instr     <= iw_instr;
                        hold_opc       <= iw_opc;
                        hold_tgt_gp    <= iw_tgt_gp;
                        hold_tgt_gp_we <= iw_tgt_gp_we;
                        hold_tgt_sr    <= iw_tgt_sr;
                        hold_tgt_sr_we <= iw_tgt_sr_we;
                        hold_result    <= iw_result;
                        hold_store     <= iw_is_store;
                        state          <= S_WAIT;
                    end else begin
                        ow_tgt_gp_we <= iw_tgt_gp_we;
                        ow_tgt_sr_we <= iw_tgt_sr_we;
                    end
                end
                S_WAIT: begin
                    if (iw_mem_ack) begin
                        ow_mem_req   <= 1'b0;
                        ow_pc        <= hold_pc;
                        ow_instr     <= hold_instr;
                        ow_opc       <= hold_opc;
                        ow_tgt_gp    <= hold_tgt_gp;
                        ow_tgt_sr    <= hold_tgt_sr;
                        ow_result    <= hold_store ? hold_result : iw_mem_rdata;
                        ow_tgt_gp_we <= hold_tgt_gp_we && !hold_store;
                        ow_tgt_sr_we <= hold_tgt_sr_we && !hold_store;
                        state        <= S_IDLE;
                    end else if (timeout) begin
                        ow_mem_req   <= 1'b0;
                        ow_tgt_gp_we <= 1'b0;
                        ow_tgt_sr_we <= 1'b0;
                        state        <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/stg_ma.md
STG_MA -- requirements
Module: stg_ma

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 16, memory-ack wait limit in cycles; used only with STG_MA_TIMEOUT_EN.
REQ-002 SHALL have ports (name direction width meaning):
- iw_clk  in  1  clock.
- iw_rst  in  1  reset, asynchronous, active-high.
- iw_pc  in  `SIZE_ADDR  execute-stage pc.
- iw_instr  in  `SIZE_DATA  instruction word.
- iw_opc  in  `SIZE_OPC  opcode.
- iw_tgt_gp  in  `SIZE_TGT_GP  gp target.
- iw_tgt_gp_we  in  1  gp write enable.
- iw_tgt_sr  in  `SIZE_TGT_SR  sr target.
- iw_tgt_sr_we  in  1  sr write enable.
- iw_result  in  `SIZE_DATA  ALU result; memory address for load/store.
- iw_store_data  in  `SIZE_DATA  store operand.
- iw_is_load  in  1  load instruction.
- iw_is_store  in  1  store instruction.
- ow_pc, ow_instr, ow_opc, ow_tgt_gp, ow_tgt_sr, ow_result  out  (widths as inputs)  registered to writeback.
- ow_tgt_gp_we, ow_tgt_sr_we  out  1  registered write enables to writeback.
- ow_mem_req  out  1  data-memory request.
- ow_mem_we  out  1  1 = store, 0 = load.
- ow_mem_addr  out  `SIZE_ADDR  address, iw_result low bits.
- ow_mem_wdata  out  `SIZE_DATA  store data.
- iw_mem_ack  in  1  memory completion.
- iw_mem_rdata  in  `SIZE_DATA  load data, valid with ack.
- ow_stall  out  1  freeze upstream stages.
- ow_mem_err  out  1  timeout flag (tied 0 without STG_MA_TIMEOUT_EN).

Function
REQ-003 SHALL implement FSM with states S_IDLE, S_WAIT.
REQ-004 In S_IDLE with neither iw_is_load nor iw_is_store: all ow_* stage outputs SHALL equal the inputs one cycle later (latency 1); result = iw_result.
REQ-005 In S_IDLE with load or store: SHALL register address/wdata/we, assert ow_mem_req next cycle, enter S_WAIT, and latch a bubble (both ow_*_we = 0) toward writeback.
REQ-006 ow_stall SHALL be combinational: 1 in S_WAIT unless iw_mem_ack, and 1 in S_IDLE when a memory op is presented; upstream holds inputs while stalled.
REQ-007 ow_mem_req, ow_mem_addr, ow_mem_we, ow_mem_wdata SHALL stay stable throughout S_WAIT until ack.
REQ-008 On iw_mem_ack in S_WAIT: deassert ow_mem_req next cycle, go S_IDLE, latch held pc/instr/opc/targets/enables; ow_result = iw_mem_rdata for load, held iw_result for store; store forces both write enables 0.
REQ-009 iw_mem_ack in S_IDLE SHALL be ignored.
REQ-010 Ack arriving the same cycle req rises SHALL complete the access (minimum 2-cycle memory op).
REQ-011 Asserting both iw_is_load and iw_is_store SHALL be treated as store.

Reset
REQ-012 Async reset SHALL force S_IDLE and zero every registered output, ow_mem_req, ow_mem_err, and any counter; ow_stall = 0 during reset.
REQ-013 Reset during S_WAIT SHALL abandon the access with no writeback.

Configuration
REQ-014 With STG_MA_TIMEOUT_EN defined: a counter SHALL count S_WAIT cycles; on reaching TIMEOUT_CYCLES without ack, drop ow_mem_req, set sticky ow_mem_err (cleared only by reset), emit bubble, return to S_IDLE.
REQ-015 Without STG_MA_TIMEOUT_EN: no counter, ow_mem_err tied 0, S_WAIT waits indefinitely.

Structure
REQ-016 SIZE_*/HBIT_* widths SHALL come from src/sizes.vh; state encodings SHALL be local params.
REQ-017 Timeout counter SHALL be sub-module stg_ma_timer; no other sub-modules.

Verification
REQ-018 Bench SHALL cover:
- ALU op pc=0x10, result=0x1234, gp_we=1 -> next cycle ow_result=0x1234, ow_tgt_gp_we=1, no req, no stall.
- Load addr 0x40, ack after 3 cycles with rdata=0xBEEF -> req held 3 cycles, stall high, then ow_result=0xBEEF, gp_we=1.
- Store addr 0x44, data 0x55AA, ack same cycle as req -> ow_mem_we=1, ow_mem_wdata=0x55AA, enables 0 at writeback.
- Reset asserted mid-S_WAIT -> next edge all outputs 0, state S_IDLE.
- Timeout build, TIMEOUT_CYCLES=4, no ack -> req drops after 4 cycles, ow_mem_err=1 sticky, bubble.
- Spurious ack in S_IDLE during ALU stream -> no output change.
